// File: rtl/multicycle_control.sv
// Multi-cycle RV32 control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, sticky TRAP.
// Define MULDIV_EN to decode funct7=0000001 multiply/divide ops that hold EXEC until AluDone.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned ALUSEL_W    = 4
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [31:0]         Instr,
  input  logic                InstrValid,
  input  logic                MemReady,
  input  logic                BrEq,
  input  logic                BrLT,
  input  logic                AluDone,
  output logic                PCSel,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                BrUn,
  output logic                ASel,
  output logic                BSel,
  output logic                MemReq,
  output logic                MemRW,
  output logic                RegWEn,
  output logic [2:0]          ImmSel,
  output logic [ALUSEL_W-1:0] ALUSel,
  output logic [1:0]          WBSel,
  output logic                Trap,
  output logic [2:0]          State
);

  typedef enum logic [2:0] {
    FETCH  = 3'b000,
    DECODE = 3'b001,
    EXEC   = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100,
    TRAP   = 3'b111
  } state_t;

  typedef enum logic [2:0] {
    K_ALU_R,
    K_ALU_I,
    K_LOAD,
    K_STORE,
    K_BRANCH,
    K_JALR,
    K_MULDIV,
    K_ILLEGAL
  } kind_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t      state;
  logic [31:0] ir;
  logic [7:0]  wait_cnt;
  kind_t       kind;
  logic [3:0]  alu_code;
  logic [3:0]  alu4;
  logic        taken;
  logic        alu_done;
  logic        unused_ok;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

`ifdef MULDIV_EN
  assign alu_done  = AluDone;
  assign unused_ok = &{1'b0, ir[24:15], ir[11:7]};
`else
  assign alu_done  = 1'b0;
  assign unused_ok = &{1'b0, ir[24:15], ir[11:7], AluDone};
`endif

  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    logic [3:0] code;
    case (f3)
      3'b000:  code = 4'b0001; // add
      3'b001:  code = 4'b0111; // sll
      3'b010:  code = 4'b1000; // slt
      3'b011:  code = 4'b1111; // sltu
      3'b100:  code = 4'b0100; // xor
      3'b101:  code = 4'b0101; // srl
      3'b110:  code = 4'b0011; // or
      default: code = 4'b0010; // and
    endcase
    return code;
  endfunction

  always_comb begin
    kind     = K_ILLEGAL;
    alu_code = 4'b0001;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          kind     = K_ALU_R;
          alu_code = base_alu(funct3);
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) begin
            kind     = K_ALU_R;
            alu_code = 4'b1101;
          end else if (funct3 == 3'b101) begin
            kind     = K_ALU_R;
            alu_code = 4'b0110;
          end
        end
`ifdef MULDIV_EN
        else if (funct7 == 7'b0000001) begin
          case (funct3)
            3'b000: begin kind = K_MULDIV; alu_code = 4'b1001; end
            3'b100: begin kind = K_MULDIV; alu_code = 4'b1010; end
            3'b101: begin kind = K_MULDIV; alu_code = 4'b1011; end
            3'b110: begin kind = K_MULDIV; alu_code = 4'b1100; end
            3'b111: begin kind = K_MULDIV; alu_code = 4'b1110; end
            default: ;
          endcase
        end
`endif
      end
      7'b0010011: begin
        kind     = K_ALU_I;
        // srai is distinguished by IR[30]; addi has no subtract form
        alu_code = (funct3 == 3'b101 && ir[30]) ? 4'b0110 : base_alu(funct3);
      end
      7'b0000011: kind = K_LOAD;
      7'b0100011: kind = K_STORE;
      7'b1100011: kind = (funct3 == 3'b010 || funct3 == 3'b011) ? K_ILLEGAL : K_BRANCH;
      7'b1100111: kind = K_JALR;
      default:    kind = K_ILLEGAL;
    endcase
  end

  // funct3[0] inverts the sense; funct3[2] chooses less-than over equality
  assign taken = funct3[2] ? (BrLT ^ funct3[0]) : (BrEq ^ funct3[0]);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= FETCH;
      ir       <= 32'h0000_0013;
      wait_cnt <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (InstrValid) begin
            ir    <= Instr;
            state <= DECODE;
          end
        end
        DECODE: state <= (kind == K_ILLEGAL) ? TRAP : EXEC;
        EXEC: begin
          case (kind)
            K_LOAD, K_STORE: begin
              wait_cnt <= '0;
              state    <= MEM;
            end
            K_BRANCH:  state <= FETCH;
            K_MULDIV:  if (alu_done) state <= WB;
            K_ILLEGAL: state <= TRAP;
            default:   state <= WB;
          endcase
        end
        MEM: begin
          if (MemReady) begin
            state <= (kind == K_STORE) ? FETCH : WB;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            state <= TRAP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WB:      state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= TRAP;
      endcase
    end
  end

  always_comb begin
    PCSel   = 1'b0;
    PCWrite = 1'b0;
    IRWrite = 1'b0;
    BrUn    = 1'b0;
    ASel    = 1'b0;
    BSel    = 1'b0;
    MemReq  = 1'b0;
    MemRW   = 1'b0;
    RegWEn  = 1'b0;
    ImmSel  = 3'b000;
    alu4    = 4'b0000;
    WBSel   = 2'b00;
    case (state)
      FETCH: IRWrite = InstrValid;
      EXEC: begin
        case (kind)
          K_ALU_R, K_MULDIV: begin
            ASel = 1'b1;
            BSel = 1'b1;
            alu4 = alu_code;
          end
          K_ALU_I: begin
            ASel = 1'b1;
            alu4 = alu_code;
          end
          K_LOAD, K_JALR: begin
            ASel = 1'b1;
            alu4 = 4'b0001;
          end
          K_STORE: begin
            ASel   = 1'b1;
            ImmSel = 3'b010;
            alu4   = 4'b0001;
          end
          K_BRANCH: begin
            ImmSel  = 3'b101;
            BrUn    = funct3[1];
            alu4    = 4'b0001;
            PCWrite = 1'b1;
            PCSel   = taken;
          end
          default: ;
        endcase
      end
      MEM: begin
        MemReq = 1'b1;
        MemRW  = (kind == K_STORE);
        if (MemReady && kind == K_STORE) PCWrite = 1'b1;
      end
      WB: begin
        RegWEn  = 1'b1;
        PCWrite = 1'b1;
        if (kind == K_LOAD) begin
          WBSel = 2'b00;
        end else if (kind == K_JALR) begin
          WBSel = 2'b10;
          PCSel = 1'b1;
        end else begin
          WBSel = 2'b01;
        end
      end
      default: ;
    endcase
  end

  assign ALUSel = ALUSEL_W'(alu4);
  assign Trap   = (state == TRAP);
  assign State  = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction cycle plans from an ISA-level model.
module tb_multicycle_control;

  localparam int unsigned TMO = 15;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [31:0] Instr;
  logic        InstrValid, MemReady, BrEq, BrLT, AluDone;
  logic        PCSel, PCWrite, IRWrite, BrUn, ASel, BSel, MemReq, MemRW, RegWEn, Trap;
  logic [2:0]  ImmSel, State;
  logic [3:0]  ALUSel;
  logic [1:0]  WBSel;

  multicycle_control #(.MEM_TIMEOUT(TMO), .ALUSEL_W(4)) dut (
    .CLK(CLK), .RSTn(RSTn), .Instr(Instr), .InstrValid(InstrValid),
    .MemReady(MemReady), .BrEq(BrEq), .BrLT(BrLT), .AluDone(AluDone),
    .PCSel(PCSel), .PCWrite(PCWrite), .IRWrite(IRWrite), .BrUn(BrUn),
    .ASel(ASel), .BSel(BSel), .MemReq(MemReq), .MemRW(MemRW), .RegWEn(RegWEn),
    .ImmSel(ImmSel), .ALUSel(ALUSel), .WBSel(WBSel), .Trap(Trap), .State(State)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] state;
    logic trap, pcsel, pcwrite, irwrite, brun, asel, bsel, memreq, memrw, regwen;
    logic [2:0] immsel;
    logic [3:0] alusel;
    logic [1:0] wbsel;
  } ctl_t;

  typedef struct {
    logic  iv, mr, ad, eq, lt;
    ctl_t  e;
    string tag;
  } step_t;

  step_t sched[$];
  ctl_t  cur_exp, act_c;
  string cur_tag;
  bit    exp_on = 1'b0;
  int    n_cmp = 0, n_bad = 0;

  logic [3:0] base_tab [8] = '{4'h1, 4'h7, 4'h8, 4'hF, 4'h4, 4'h5, 4'h3, 4'h2};
`ifdef MULDIV_EN
  logic [3:0] md_tab [8] = '{4'h9, 4'h0, 4'h0, 4'h0, 4'hA, 4'hB, 4'hC, 4'hE};
`endif

  int         obs_cyc, obs_irw, obs_gap, obs_memreq, obs_wb, obs_exec;
  logic       obs_memrw, obs_pcw_mem, obs_pcsel_exec, obs_exec_seen;
  logic [3:0] obs_alu;
  logic [1:0] obs_wbsel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_on) begin
      act_c = {State, Trap, PCSel, PCWrite, IRWrite, BrUn, ASel, BSel, MemReq, MemRW,
               RegWEn, ImmSel, ALUSel, WBSel};
      check(cur_tag, 32'(act_c), 32'(cur_exp));
    end
  end

  function automatic ctl_t idle(input logic [2:0] st);
    ctl_t c = '0;
    c.state = st;
    c.trap  = (st == 3'b111);
    return c;
  endfunction

  task automatic push(input ctl_t e, input string tag, input logic iv, input logic mr,
                      input logic ad, input logic eq, input logic lt);
    step_t s;
    s.iv = iv; s.mr = mr; s.ad = ad; s.eq = eq; s.lt = lt; s.e = e; s.tag = tag;
    sched.push_back(s);
  endtask

  // kind: 0 R-ALU, 1 I-ALU, 2 load, 3 store, 4 branch, 5 jalr, 6 mul/div, -1 illegal
  task automatic plan(input logic [31:0] ins, input int stall, input int mem_lat,
                      input int alu_lat, input logic eq, input logic lt);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [3:0] code;
    ctl_t       c;
    int         kind;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    for (int i = 0; i < stall; i++) push(idle(3'd0), "fetch-wait", 0, 0, 0, eq, lt);
    c = idle(3'd0); c.irwrite = 1'b1;
    push(c, "fetch", 1, 0, 0, eq, lt);
    push(idle(3'd1), "decode", 0, 0, 0, eq, lt);
    kind = -1; code = 4'h1;
    if (op == 7'h33) begin
      if (f7 == 7'h00) begin kind = 0; code = base_tab[f3]; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin kind = 0; code = 4'hD; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin kind = 0; code = 4'h6; end
`ifdef MULDIV_EN
      else if (f7 == 7'h01 && md_tab[f3] != 4'h0) begin kind = 6; code = md_tab[f3]; end
`endif
    end else if (op == 7'h13) begin
      kind = 1;
      code = (f3 == 3'd5 && ins[30]) ? 4'h6 : base_tab[f3];
    end else if (op == 7'h03) kind = 2;
    else if (op == 7'h23) kind = 3;
    else if (op == 7'h63 && f3 != 3'd2 && f3 != 3'd3) kind = 4;
    else if (op == 7'h67) kind = 5;

    if (kind < 0) begin
      for (int i = 0; i < 3; i++) push(idle(3'd7), "trap-illegal", 0, 0, 0, eq, lt);
      return;
    end

    c = idle(3'd2);
    case (kind)
      0: begin c.asel = 1; c.bsel = 1; c.alusel = code; push(c, "exec-r", 0, 0, 0, eq, lt); end
      1: begin c.asel = 1; c.alusel = code; push(c, "exec-i", 0, 0, 0, eq, lt); end
      2, 3: begin
        c.asel = 1; c.alusel = 4'h1; c.immsel = (kind == 3) ? 3'b010 : 3'b000;
        push(c, "exec-ldst", 0, 0, 0, eq, lt);
      end
      4: begin
        c.immsel = 3'b101; c.brun = f3[1]; c.alusel = 4'h1; c.pcwrite = 1;
        case (f3)
          3'd0:       c.pcsel = eq;
          3'd1:       c.pcsel = !eq;
          3'd4, 3'd6: c.pcsel = lt;
          default:    c.pcsel = !lt;
        endcase
        push(c, "exec-branch", 0, 0, 0, eq, lt);
        push(idle(3'd0), "fetch-next", 0, 0, 0, eq, lt);
        return;
      end
      5: begin c.asel = 1; c.alusel = 4'h1; push(c, "exec-jalr", 0, 0, 0, eq, lt); end
      default: begin
        c.asel = 1; c.bsel = 1; c.alusel = code;
        for (int i = 0; i < alu_lat; i++) push(c, "exec-md-wait", 0, 0, 0, eq, lt);
        push(c, "exec-md-done", 0, 0, 1, eq, lt);
      end
    endcase

    if (kind == 2 || kind == 3) begin
      c = idle(3'd3); c.memreq = 1; c.memrw = (kind == 3);
      if (mem_lat > int'(TMO) + 1) begin
        for (int i = 0; i < int'(TMO) + 1; i++) push(c, "mem-wait", 0, 0, 0, eq, lt);
        for (int i = 0; i < 3; i++) push(idle(3'd7), "trap-timeout", 0, 0, 0, eq, lt);
        return;
      end
      for (int i = 0; i < mem_lat - 1; i++) push(c, "mem-wait", 0, 0, 0, eq, lt);
      if (kind == 3) c.pcwrite = 1;
      push(c, "mem-done", 0, 1, 0, eq, lt);
      if (kind == 3) begin
        push(idle(3'd0), "fetch-next", 0, 0, 0, eq, lt);
        return;
      end
    end

    c = idle(3'd4); c.regwen = 1; c.pcwrite = 1; c.pcsel = (kind == 5);
    c.wbsel = (kind == 2) ? 2'b00 : (kind == 5) ? 2'b10 : 2'b01;
    push(c, "wb", 0, 0, 0, eq, lt);
    push(idle(3'd0), "fetch-next", 0, 0, 0, eq, lt);
  endtask

  task automatic observe();
    if (IRWrite && obs_irw < 0) obs_irw = obs_cyc;
    if (obs_irw >= 0 && obs_gap < 0 && obs_cyc > obs_irw && State == 3'd0) obs_gap = obs_cyc - obs_irw;
    if (MemReq) begin
      obs_memreq++;
      obs_memrw = MemRW;
      if (PCWrite) obs_pcw_mem = 1'b1;
    end
    if (State == 3'd2) begin
      obs_exec++;
      if (!obs_exec_seen) begin
        obs_alu = ALUSel; obs_pcsel_exec = PCSel; obs_exec_seen = 1'b1;
      end
    end
    if (State == 3'd4) begin obs_wb++; obs_wbsel = WBSel; end
    obs_cyc++;
  endtask

  // Called at posedge+1; consumes up to max_steps cycles of the plan, then discards the rest.
  task automatic run(input logic [31:0] ins, input int max_steps);
    step_t s;
    int    n = 0;
    obs_cyc = 0; obs_irw = -1; obs_gap = -1; obs_memreq = 0; obs_wb = 0; obs_exec = 0;
    obs_memrw = 0; obs_pcw_mem = 0; obs_pcsel_exec = 0; obs_exec_seen = 0;
    obs_alu = 4'h0; obs_wbsel = 2'b11;
    Instr = ins;
    while (sched.size() > 0 && n < max_steps) begin
      s = sched.pop_front();
      InstrValid = s.iv; MemReady = s.mr; AluDone = s.ad; BrEq = s.eq; BrLT = s.lt;
      cur_exp = s.e; cur_tag = s.tag; exp_on = 1'b1;
      #1;
      observe();
      @(posedge CLK); #1;
      n++;
    end
    sched.delete();
    InstrValid = 0; MemReady = 0; AluDone = 0;
  endtask

  task automatic do_reset();
    InstrValid = 0; MemReady = 0; AluDone = 0;
    cur_exp = idle(3'd0); cur_tag = "reset"; exp_on = 1'b1;
    RSTn = 1'b0;
    #1;
    check("reset-state", 32'(State), 32'd0);
    check("reset-trap", 32'(Trap), 32'd0);
    check("reset-memreq", 32'(MemReq), 32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    RSTn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    Instr = '0; InstrValid = 0; MemReady = 0; BrEq = 0; BrLT = 0; AluDone = 0;
    do_reset();

    plan(32'h002081B3, 1, 0, 0, 0, 0); run(32'h002081B3, 100);
    check("add-alusel", 32'(obs_alu), 32'h1);
    check("add-fetch-gap", 32'(obs_gap), 32'd4);
    check("add-wbsel", 32'(obs_wbsel), 32'h1);

    plan(32'h402081B3, 1, 0, 0, 0, 0); run(32'h402081B3, 100);
    check("sub-alusel", 32'(obs_alu), 32'hD);
    plan(32'h0020C1B3, 1, 0, 0, 0, 0); run(32'h0020C1B3, 100);
    check("xor-alusel", 32'(obs_alu), 32'h4);
    plan(32'h00500093, 2, 0, 0, 0, 0); run(32'h00500093, 100);
    check("addi-alusel", 32'(obs_alu), 32'h1);
    plan(32'h4030D093, 1, 0, 0, 0, 0); run(32'h4030D093, 100);
    check("srai-alusel", 32'(obs_alu), 32'h6);

    plan(32'h0000A103, 1, 3, 0, 0, 0); run(32'h0000A103, 100);
    check("lw-memreq-cycles", 32'(obs_memreq), 32'd3);
    check("lw-memrw", 32'(obs_memrw), 32'd0);
    check("lw-wbsel", 32'(obs_wbsel), 32'h0);
    plan(32'h0020A023, 1, 3, 0, 0, 0); run(32'h0020A023, 100);
    check("sw-memreq-cycles", 32'(obs_memreq), 32'd3);
    check("sw-memrw", 32'(obs_memrw), 32'd1);
    check("sw-no-wb", 32'(obs_wb), 32'd0);
    check("sw-pcwrite", 32'(obs_pcw_mem), 32'd1);

    plan(32'h00208463, 1, 0, 0, 1, 0); run(32'h00208463, 100);
    check("beq-taken-pcsel", 32'(obs_pcsel_exec), 32'd1);
    plan(32'h00208463, 1, 0, 0, 0, 1); run(32'h00208463, 100);
    check("beq-not-taken-pcsel", 32'(obs_pcsel_exec), 32'd0);
    plan(32'h0020E463, 1, 0, 0, 0, 1); run(32'h0020E463, 100);
    check("bltu-taken-pcsel", 32'(obs_pcsel_exec), 32'd1);
    plan(32'h000080E7, 1, 0, 0, 0, 0); run(32'h000080E7, 100);
    check("jalr-wbsel", 32'(obs_wbsel), 32'h2);

    // MemReady on the last allowed MEM cycle still completes the store
    plan(32'h0020A023, 1, int'(TMO) + 1, 0, 0, 0); run(32'h0020A023, 100);
    check("sw-edge-memreq-cycles", 32'(obs_memreq), 32'(TMO + 1));
    check("sw-edge-pcwrite", 32'(obs_pcw_mem), 32'd1);
    check("sw-edge-no-trap", 32'(Trap), 32'd0);

    plan(32'h022081B3, 1, 0, 2, 0, 0); run(32'h022081B3, 100);
`ifdef MULDIV_EN
    check("mul-alusel", 32'(obs_alu), 32'h9);
    check("mul-exec-cycles", 32'(obs_exec), 32'd3);
    check("mul-wb", 32'(obs_wb), 32'd1);
`else
    check("mul-trap", 32'(Trap), 32'd1);
    do_reset();
`endif

    plan(32'h0020A023, 1, 1000, 0, 0, 0); run(32'h0020A023, 100);
    check("sw-timeout-memreq-cycles", 32'(obs_memreq), 32'(TMO + 1));
    check("sw-timeout-trap", 32'(Trap), 32'd1);
    check("sw-timeout-state", 32'(State), 32'h7);
    do_reset();

    plan(32'h0000007F, 1, 0, 0, 0, 0); run(32'h0000007F, 100);
    check("illegal-op-trap", 32'(Trap), 32'd1);
    do_reset();
    plan(32'h0020A463, 1, 0, 0, 0, 0); run(32'h0020A463, 100);
    check("branch-f3-010-trap", 32'(Trap), 32'd1);
    do_reset();

    // Asynchronous reset in the middle of a memory access
    plan(32'h0020A023, 1, 1000, 0, 0, 0); run(32'h0020A023, 5);
    exp_on = 1'b0;
    #1;
    check("pre-reset-memreq", 32'(MemReq), 32'd1);
    #1;
    RSTn = 1'b0;
    #1;
    check("async-reset-state", 32'(State), 32'd0);
    check("async-reset-memreq", 32'(MemReq), 32'd0);
    cur_exp = idle(3'd0); cur_tag = "reset-hold"; exp_on = 1'b1;
    @(posedge CLK); #1;
    RSTn = 1'b1;

    plan(32'h002081B3, 1, 0, 0, 0, 0); run(32'h002081B3, 100);
    check("post-reset-add-gap", 32'(obs_gap), 32'd4);

    exp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum cycles waiting for MemReady in MEM before entering TRAP (range 1..255).
REQ-002 SHALL have parameter ALUSEL_W, default 4: ALUSel width; the codes below are zero-extended when ALUSEL_W > 4.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RSTn  in  1  asynchronous, active-low reset.
REQ-005 Instr  in  32  fetched instruction; valid when InstrValid=1.
REQ-006 InstrValid  in  1  fetch data valid.
REQ-007 MemReady  in  1  data-memory access complete.
REQ-008 BrEq, BrLT  in  1 each  branch comparator results.
REQ-009 AluDone  in  1  multi-cycle ALU result ready.
REQ-010 PCSel, PCWrite, IRWrite, BrUn, ASel, BSel, MemReq, MemRW, RegWEn  out  1 each  datapath controls.
REQ-011 ImmSel  out  3; ALUSel  out  ALUSEL_W; WBSel  out  2  datapath selects.
REQ-012 Trap  out  1  illegal instruction or memory timeout, sticky.
REQ-013 State  out  3  current FSM state.

Function
REQ-014 FSM states SHALL be FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, TRAP=111.
REQ-015 Outputs SHALL be combinational from State and the internal 32-bit IR; any output not asserted by the current state SHALL be driven 0, never x.
REQ-016 FETCH: hold until InstrValid=1, then pulse IRWrite=1, load IR from Instr, go to DECODE.
REQ-017 DECODE: one cycle; opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1100111} -> TRAP; otherwise -> EXEC.
REQ-018 ALUSel SHALL be add 0001, sub 1101, sll 0111, slt 1000, sltu 1111, xor 0100, srl 0101, sra 0110, or 0011, and 0010.
REQ-019 sub and sra SHALL be selected only when funct7=0100000; funct7=0000000 selects add/srl; any other R-type funct7 -> TRAP, except as REQ-030 permits.
REQ-020 I-type ALU ops SHALL use the same codes with ImmSel=000; srai SHALL be selected by IR[30]; addi never decodes to sub.
REQ-021 EXEC for R/I-ALU: ASel=1, BSel=R?1:0, ALUSel per decode; -> WB.
REQ-022 EXEC for load/store: ALUSel=0001, ASel=1, BSel=0, ImmSel=000 (load) or 010 (store); -> MEM.
REQ-023 EXEC for branch: ImmSel=101, BrUn=funct3[1], ASel=0, BSel=0, ALUSel=0001. Taken = BrEq (beq), ~BrEq (bne), BrLT (blt/bltu), ~BrLT (bge/bgeu). PCWrite=1, PCSel=taken; -> FETCH. funct3 010/011 -> TRAP.
REQ-024 EXEC for jalr: ASel=1, BSel=0, ImmSel=000, ALUSel=0001; -> WB.
REQ-025 MEM: MemReq=1, MemRW=1 for store and 0 for load, held until MemReady=1. On MemReady, load -> WB; store asserts PCWrite=1 with PCSel=0 -> FETCH.
REQ-026 MEM wait counter SHALL clear on MEM entry. If MemReady has not been seen after MEM_TIMEOUT+1 cycles in MEM, the FSM SHALL go to TRAP. MemReady on the final allowed cycle completes normally.
REQ-027 WB: one cycle; RegWEn=1, WBSel=00 (load), 01 (ALU), 10 (jalr); PCWrite=1, PCSel=1 for jalr else 0; -> FETCH.
REQ-028 TRAP: Trap=1, all other controls 0; remain until reset.

Reset
REQ-029 On RSTn=0, immediately and independently of CLK: State=FETCH, IR=0x00000013, wait counter=0, Trap=0. Reset asserted mid-MEM or mid-EXEC SHALL abort the access with MemReq=0 in the same cycle.

Configuration
REQ-030 MULDIV_EN defined: R-type with funct7=0000001 SHALL decode mul 1001, div 1010, divu 1011, rem 1100, remu 1110 (funct3 000/100/101/110/111). EXEC holds these ops until AluDone=1, then -> WB. funct3 001/010/011 -> TRAP.
REQ-031 MULDIV_EN undefined: funct7=0000001 SHALL -> TRAP, and AluDone is ignored.

Verification
REQ-032 Instr=0x002081B3 (add) with InstrValid: DECODE, then EXEC with ALUSel=0001; WB with RegWEn=1, WBSel=01; FETCH 4 cycles after IRWrite.
REQ-033 Instr=0x402081B3 (sub) -> ALUSel=1101 in EXEC; Instr=0x0020C1B3 (xor) -> 0100.
REQ-034 Instr=0x0000A103 (lw) with MemReady after 3 cycles: MemReq=1 for exactly 3 cycles, MemRW=0; then WB with WBSel=00. Repeat with Instr=0x0020A023 (sw): MemRW=1, no WB, PCWrite=1.
REQ-035 Instr=0x00208463 (beq): BrEq=1 gives PCSel=1, PCWrite=1 in EXEC; BrEq=0 gives PCSel=0; FETCH follows in both cases.
REQ-036 sw with MemReady held 0 and MEM_TIMEOUT=15 -> TRAP after 16 MEM cycles with Trap=1. Separately, RSTn pulsed low mid-MEM -> State=000 and MemReq=0 asynchronously.
REQ-037 Instr=0x022081B3 (mul): with MULDIV_EN, ALUSel=1001 is held until AluDone=1, then WB; without MULDIV_EN -> TRAP after DECODE.
